// File: rtl/zx81_tape_player_if.sv
// ---------------------------------------------------------------------------
// zx81_tape_player_if
// Control, tape RAM read and tape line signals of the ZX81 tape player.
//   ce        : timing enable (one tick per ce=1 cycle, 6.5 MHz pacing)
//   start     : one-clk playback request
//   stop      : one-clk abort
//   tape_len  : number of bytes to play, sampled on start
//   rd_addr   : tape RAM read address (from player)
//   rd_data   : tape RAM data, registered sync RAM (to player)
//   tape_out  : 1 = pulse present on the tape line
//   busy      : playback in progress
//   done      : one-clk pulse at the end of playback
// Modports: master = host/RAM side, slave = player.
// ---------------------------------------------------------------------------
interface zx81_tape_player_if #(
  parameter int ADDR_W = 14
);
  logic              ce;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] tape_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tape_out;
  logic              busy;
  logic              done;

  modport master (
    output ce, start, stop, tape_len, rd_data,
    input  rd_addr, tape_out, busy, done
  );

  modport slave (
    input  ce, start, stop, tape_len, rd_data,
    output rd_addr, tape_out, busy, done
  );
endinterface

// File: rtl/zx81_tape_player.sv
// ---------------------------------------------------------------------------
// zx81_tape_player
// Real-speed ZX81 tape transmitter. Reads bytes of a .p image from tape RAM
// and serialises them MSB first as pulse trains: a 0 bit is 4 pulses, a 1 bit
// is 9 pulses, each bit followed by a silent gap. A silent leader precedes
// the first byte.
// Ports:
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   io_bus  : zx81_tape_player_if.slave (ce, start, stop, tape_len,
//             rd_addr, rd_data, tape_out, busy, done)
// Optional build macro TAPE_NAME_EN: when defined, a synthetic name byte
// 8'h80 (empty name, terminator bit set) is sent after the leader and before
// RAM byte 0, without a RAM read; rd_addr stays 0 for that byte.
// ---------------------------------------------------------------------------
module zx81_tape_player #(
  parameter int ADDR_W         = 14,
  parameter int PULSE_HI_TICKS = 975,
  parameter int PULSE_LO_TICKS = 975,
  parameter int GAP_TICKS      = 8450,
  parameter int LEADER_TICKS   = 3250000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  zx81_tape_player_if.slave    io_bus
);

  localparam int MAX_A     = (PULSE_HI_TICKS > PULSE_LO_TICKS) ? PULSE_HI_TICKS : PULSE_LO_TICKS;
  localparam int MAX_B     = (GAP_TICKS > LEADER_TICKS) ? GAP_TICKS : LEADER_TICKS;
  localparam int MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEADER, S_FETCH, S_PULSE_HI, S_PULSE_LO, S_GAP, S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_sr;
  logic [2:0]        r_bc;
  logic [3:0]        r_pc;
  logic              r_fcnt;
  logic              r_tape_out;
  logic              r_busy;
  logic              r_done;
`ifdef TAPE_NAME_EN
  logic              r_name;
`endif

  logic [CNT_W-1:0]  w_last_tick;
  logic              w_timed;
  logic              w_phase_end;
  logic [ADDR_W-1:0] w_idx_inc;
  logic [3:0]        w_pc_next;

  // Terminal count of the current timed phase
  always_comb begin
    w_last_tick = '0;
    w_timed     = 1'b1;
    case (r_state)
      S_LEADER:   w_last_tick = CNT_W'(LEADER_TICKS - 1);
      S_PULSE_HI: w_last_tick = CNT_W'(PULSE_HI_TICKS - 1);
      S_PULSE_LO: w_last_tick = CNT_W'(PULSE_LO_TICKS - 1);
      S_GAP:      w_last_tick = CNT_W'(GAP_TICKS - 1);
      default:    w_timed     = 1'b0;
    endcase
  end

  assign w_phase_end = w_timed && io_bus.ce && (r_cnt == w_last_tick);
  assign w_idx_inc   = r_idx + ADDR_W'(1);
  // Pulse count of the bit that becomes MSB after the next shift
  assign w_pc_next   = r_sr[6] ? 4'd9 : 4'd4;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_rd_addr  <= '0;
      r_sr       <= '0;
      r_bc       <= '0;
      r_pc       <= '0;
      r_fcnt     <= 1'b0;
      r_tape_out <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TAPE_NAME_EN
      r_name     <= 1'b0;
`endif
    end else if (io_bus.stop) begin
      // Abort wins over everything, including a simultaneous start
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fcnt     <= 1'b0;
      r_rd_addr  <= '0;
      r_tape_out <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TAPE_NAME_EN
      r_name     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // Tick counter: advances on ce, clears on the terminal tick
      if (w_timed && io_bus.ce)
        r_cnt <= w_phase_end ? '0 : r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_len     <= io_bus.tape_len;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_LEADER;
          end
        end

        S_LEADER: begin
          if (w_phase_end) begin
`ifdef TAPE_NAME_EN
            r_name     <= 1'b1;
            r_sr       <= 8'h80;
            r_bc       <= 3'd7;
            r_pc       <= 4'd9;
            r_tape_out <= 1'b1;
            r_state    <= S_PULSE_HI;
`else
            if (r_len == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_rd_addr <= r_idx;
              r_fcnt    <= 1'b0;
              r_state   <= S_FETCH;
            end
`endif
          end
        end

        // Address was driven on entry; the RAM output is valid on the
        // second edge after that, so sample on the second FETCH cycle.
        S_FETCH: begin
          if (!r_fcnt) begin
            r_fcnt <= 1'b1;
          end else begin
            r_fcnt     <= 1'b0;
            r_sr       <= io_bus.rd_data;
            r_bc       <= 3'd7;
            r_pc       <= io_bus.rd_data[7] ? 4'd9 : 4'd4;
            r_tape_out <= 1'b1;
            r_state    <= S_PULSE_HI;
          end
        end

        S_PULSE_HI: begin
          if (w_phase_end) begin
            r_tape_out <= 1'b0;
            r_state    <= S_PULSE_LO;
          end
        end

        S_PULSE_LO: begin
          if (w_phase_end) begin
            r_pc <= r_pc - 4'd1;
            if (r_pc == 4'd1) begin
              r_state <= S_GAP;
            end else begin
              r_tape_out <= 1'b1;
              r_state    <= S_PULSE_HI;
            end
          end
        end

        S_GAP: begin
          if (w_phase_end) begin
            if (r_bc != 3'd0) begin
              r_sr       <= {r_sr[6:0], 1'b0};
              r_bc       <= r_bc - 3'd1;
              r_pc       <= w_pc_next;
              r_tape_out <= 1'b1;
              r_state    <= S_PULSE_HI;
`ifdef TAPE_NAME_EN
            end else if (r_name) begin
              // Name byte finished: idx stays 0 for the first RAM byte
              r_name <= 1'b0;
              if (r_len == '0) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_rd_addr <= r_idx;
                r_fcnt    <= 1'b0;
                r_state   <= S_FETCH;
              end
`endif
            end else begin
              r_idx <= w_idx_inc;
              if (w_idx_inc == r_len) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_rd_addr <= w_idx_inc;
                r_fcnt    <= 1'b0;
                r_state   <= S_FETCH;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.rd_addr  = r_rd_addr;
  assign io_bus.tape_out = r_tape_out;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;

endmodule

// File: tb/tb_zx81_tape_player.sv
// ---------------------------------------------------------------------------
// tb_zx81_tape_player
// Scoreboard bench for zx81_tape_player with short timing (HI=2, LO=2,
// GAP=10, LEADER=20, ce=1 every clock). Each playback pushes its expected
// pulse groups (pulses per bit, byte address) and the done pulse into a
// queue; a monitor reconstructs groups from tape_out and pops/compares.
// Build with +define+TAPE_NAME_EN to exercise the synthetic name byte.
// ---------------------------------------------------------------------------
module tb_zx81_tape_player;
  localparam int AW  = 14;
  localparam int HI  = 2;
  localparam int LO  = 2;
  localparam int GAP = 10;
  localparam int LDR = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zx81_tape_player_if #(.ADDR_W(AW)) bus ();

  zx81_tape_player #(
    .ADDR_W(AW), .PULSE_HI_TICKS(HI), .PULSE_LO_TICKS(LO),
    .GAP_TICKS(GAP), .LEADER_TICKS(LDR)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .io_bus (bus)
  );

  // Registered sync tape RAM
  logic [7:0] ram [0:15];
  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr[3:0]];

  typedef struct {
    bit is_done;
    int cnt;
    int addr;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  int  high_total = 0;
  int  hi_run, lo_run, grp_cnt, grp_addr;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic emit(input bit d, input int c, input int a);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got done=%0d pulses=%0d addr=%0d, required nothing", d, c, a);
    end else begin
      e = sb.pop_front();
      $display("event done=%0d pulses=%0d addr=%0d", d, c, a);
      chk("event_kind", int'(d), int'(e.is_done));
      if (!d) begin
        chk("pulse_count", c, e.cnt);
        chk("byte_addr", a, e.addr);
      end
    end
  endtask

  // Monitor: rebuild pulse groups from tape_out; a low run longer than LO ends a group
  initial begin
    hi_run = 0; lo_run = LO + 1; grp_cnt = 0; grp_addr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        hi_run = 0; lo_run = LO + 1; grp_cnt = 0;
      end else begin
        if (bus.tape_out) begin
          if (hi_run == 0) begin
            if (grp_cnt == 0) grp_addr = int'(bus.rd_addr);
            grp_cnt++;
          end
          hi_run++;
          lo_run = 0;
          high_total++;
        end else begin
          if (hi_run > 0) begin
            chk("pulse_width", hi_run, HI);
            hi_run = 0;
          end
          lo_run++;
          if (lo_run == LO + 1 && grp_cnt > 0) begin
            emit(1'b0, grp_cnt, grp_addr);
            grp_cnt = 0;
          end
        end
        if (bus.done) emit(1'b1, 0, 0);
      end
    end
  end

  function automatic int push_byte(input logic [7:0] b, input int addr);
    int n = 0;
    ev_t e;
    for (int i = 7; i >= 0; i--) begin
      e.is_done = 1'b0;
      e.cnt     = b[i] ? 9 : 4;
      e.addr    = addr;
      sb.push_back(e);
      n += e.cnt;
    end
    return n;
  endfunction

  task automatic play(input int len, input bit inject_start);
    int  pulses = 0;
    int  n = 0;
    int  exp_lat;
    bit  got_done = 1'b0;
    ev_t e;
    high_total = 0;
`ifdef TAPE_NAME_EN
    pulses += push_byte(8'h80, 0);
    exp_lat = LDR;
`else
    exp_lat = (len == 0) ? LDR : LDR + 2;
`endif
    for (int k = 0; k < len; k++) pulses += push_byte(ram[k], k);
    e.is_done = 1'b1; e.cnt = 0; e.addr = 0;
    sb.push_back(e);

    @(negedge clk);
    bus.tape_len = AW'(len);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    chk("busy_on_start", int'(bus.busy), 1);

    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) got_done = 1'b1;
      if (bus.tape_out || bus.done) break;
    end
    chk("leader_latency", n, exp_lat);

    if (inject_start && !got_done) begin
      // Land in PULSE_LO of the first pulse, while busy
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.tape_len = AW'(5);
      @(negedge clk);
      bus.start    = 1'b0;
    end

    n = 0;
    while (!got_done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) got_done = 1'b1;
    end
    chk("done_seen", int'(got_done), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_done", int'(bus.busy), 0);
    chk("scoreboard_drained", sb.size(), 0);
    chk("high_cycles", high_total, HI * pulses);
    $display("play len=%0d pulses=%0d high=%0d", len, pulses, high_total);
    sb.delete();
  endtask

  initial begin
    int rises;
    int hits;
    int n;
    bit prev;
    bus.ce = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.tape_len = '0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tape_out", int'(bus.tape_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // One byte A0
    ram[0] = 8'hA0;
    play(1, 1'b0);
    // Empty tape
    play(0, 1'b0);
    // Three bytes 00 FF 01
    ram[0] = 8'h00; ram[1] = 8'hFF; ram[2] = 8'h01;
    play(3, 1'b0);

    // Stop during the 3rd pulse
    mon_en = 1'b0;
    ram[0] = 8'hA0;
    @(negedge clk);
    bus.tape_len = AW'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 3 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.tape_out && !prev) rises++;
      prev = bus.tape_out;
    end
    chk("third_pulse_seen", rises, 3);
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    chk("stop_tape_out", int'(bus.tape_out), 0);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_done", int'(bus.done), 0);
    @(negedge clk);
    bus.stop = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.tape_out) hits++;
    end
    chk("idle_after_stop", hits, 0);
    mon_en = 1'b1;
    play(1, 1'b0);

    // Start while busy is ignored
    play(1, 1'b1);

    // Asynchronous reset during the first gap
    mon_en = 1'b0;
    @(negedge clk);
    bus.tape_len = AW'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 9 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.tape_out && prev) rises++;
      prev = bus.tape_out;
    end
    chk("nine_pulses_seen", rises, 9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    chk("busy_before_rst", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_tape_out", int'(bus.tape_out), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_rd_addr", int'(bus.rd_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) hits++;
    end
    chk("idle_after_rst", hits, 0);
    mon_en = 1'b1;

    // Single zero byte (name-byte case when the macro is enabled)
    ram[0] = 8'h00;
    play(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
